// File: rtl/mux_scan_n.sv
// -----------------------------------------------------------------------------
// mux_scan_n
//
// Purpose:
//   N-channel, W-bit registered multiplexer with two operating modes:
//     - manual (mode=0): the channel on the output follows 'sel' directly.
//     - auto-scan (mode=1): the output steps through the channels whose 'en'
//       bit is set, dwelling DIV clock cycles on each one. This is intended for
//       time-multiplexed display digits or for sampling a set of buses.
//   The output data, the channel index and the valid flag are registered on the
//   same edge from the same next-channel value, so they always describe the
//   same channel.
//
// Parameters:
//   N      number of input channels (>= 2)
//   W      data width per channel (>= 1)
//   DIV    clock cycles spent on each channel in scan mode (>= 1)
//   SEL_W  select/index width, must equal $clog2(N)
//
// Ports:
//   clk     in   1        system clock, all state on the rising edge
//   rst     in   1        synchronous reset, active-high, dominates everything
//   mode    in   1        0 = manual select, 1 = auto-scan
//   sel     in   SEL_W    channel select (manual mode only)
//   en      in   N        per-channel enable mask (scan mode only)
//   d       in   N*W      flattened channel data, channel k at d[k*W +: W]
//   q       out  W        registered selected data
//   ch      out  SEL_W    registered index of the channel currently on q
//   valid   out  1        q/ch describe a legitimate channel
//   tick    out  1        one-cycle pulse in the cycle ch has just advanced
//                         in scan mode
//   sel_oh  out  N        (only with MUX_SCAN_ONEHOT_EN defined) registered
//                         one-hot of the channel on q, zero when not valid;
//                         meant as a direct digit-anode drive
//
// Build option:
//   MUX_SCAN_ONEHOT_EN  when defined, adds the sel_oh output and its register.
//                       When undefined the port and its logic are absent and
//                       everything else behaves identically.
// -----------------------------------------------------------------------------
module mux_scan_n #(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int DIV   = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N-1:0]     en,
  input  logic [N*W-1:0]   d,
  output logic [W-1:0]     q,
  output logic [SEL_W-1:0] ch,
  output logic             valid,
  output logic             tick
`ifdef MUX_SCAN_ONEHOT_EN
  ,
  output logic [N-1:0]     sel_oh
`endif
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if (SEL_W != $clog2(N)) begin : g_bad_sel_w
      $error("mux_scan_n: SEL_W (%0d) must equal clog2(N) (%0d)", SEL_W, $clog2(N));
    end
    if (N < 2) begin : g_bad_n
      $error("mux_scan_n: N (%0d) must be at least 2", N);
    end
    if (W < 1) begin : g_bad_w
      $error("mux_scan_n: W (%0d) must be at least 1", W);
    end
    if (DIV < 1) begin : g_bad_div
      $error("mux_scan_n: DIV (%0d) must be at least 1", DIV);
    end
  endgenerate

  // Prescaler width; DIV=1 still gets a one-bit counter that simply stays at 0.
  localparam int                PCNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(DIV - 1);
  localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

  // Channel index arithmetic is done one bit wider so that ch+i and the
  // sel>=N test never overflow, whatever N is.
  localparam int                IDX_W     = SEL_W + 1;
  localparam logic [IDX_W-1:0]  N_IDX     = IDX_W'(N);

  // ---------------------------------------------------------------------------
  // Unpack the flattened data bus into one word per channel
  // ---------------------------------------------------------------------------
  logic [W-1:0] d_ch [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign d_ch[gi] = d[gi*W +: W];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [W-1:0]      data_q,  data_d;
  logic [SEL_W-1:0]  ch_q,    ch_d;      // ch_d is the "next channel" value
  logic              valid_q, valid_d;
  logic              tick_q,  tick_d;
  logic [PCNT_W-1:0] pcnt_q,  pcnt_d;

  // ---------------------------------------------------------------------------
  // Next enabled channel after ch_q, searching ch+1, ch+2, ... with wrap.
  // The last candidate examined is ch_q itself, so when only the current
  // channel is enabled the search lands back on it. If en is all zero nothing
  // is found and scan_next stays at ch_q (the caller never advances then).
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] scan_next;
  logic             scan_found;

  always_comb begin
    scan_next  = ch_q;
    scan_found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      logic [IDX_W-1:0] cand;
      cand = {1'b0, ch_q} + IDX_W'(i);
      if (cand >= N_IDX) begin
        cand = cand - N_IDX;
      end
      if (!scan_found && en[cand[SEL_W-1:0]]) begin
        scan_next  = cand[SEL_W-1:0];
        scan_found = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Manual select with out-of-range protection (only reachable for
  // non-power-of-two N).
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] sel_safe;

  always_comb begin
    sel_safe = sel;
    if ({1'b0, sel} >= N_IDX) begin
      sel_safe = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic pcnt_at_last;
  logic any_en;

  assign pcnt_at_last = (pcnt_q == PCNT_LAST);
  assign any_en       = |en;

  always_comb begin
    data_d  = '0;
    ch_d    = ch_q;
    valid_d = 1'b0;
    tick_d  = 1'b0;
    pcnt_d  = '0;

    if (!mode) begin
      // Manual: follow sel; the prescaler is held at 0 so that a later switch
      // to scan gives a full DIV dwell on the current channel first.
      ch_d    = sel_safe;
      data_d  = d_ch[sel_safe];
      valid_d = 1'b1;
    end else begin
      // Scan: the prescaler free-runs, even while en is all zero.
      pcnt_d = pcnt_at_last ? '0 : (pcnt_q + PCNT_ONE);

      if (any_en) begin
        if (pcnt_at_last) begin
          ch_d   = scan_next;
          tick_d = 1'b1;
        end
        // A channel disabled mid-dwell keeps refreshing its data but reports
        // invalid until the next advance moves off it.
        data_d  = d_ch[ch_d];
        valid_d = en[ch_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      tick_q  <= tick_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign q     = data_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign tick  = tick_q;

`ifdef MUX_SCAN_ONEHOT_EN
  // ---------------------------------------------------------------------------
  // One-hot channel drive, registered alongside q/ch/valid
  // ---------------------------------------------------------------------------
  logic [N-1:0] sel_oh_q, sel_oh_d;

  always_comb begin
    sel_oh_d = '0;
    if (valid_d) begin
      sel_oh_d = N'(1) << ch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_oh_q <= '0;
    end else begin
      sel_oh_q <= sel_oh_d;
    end
  end

  assign sel_oh = sel_oh_q;
`endif

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
Parametrised N-channel, W-bit registered multiplexer. Adds an auto-scan mode that steps through the enabled channels at a programmable rate, for time-multiplexed display digits or sampled buses in the lab designs. A manual mode keeps direct-select behaviour. Output data, channel index and valid are registered together, so all three always describe the same channel.

Parameters:
N, 4, number of input channels (>=2)
W, 1, data width per channel (>=1)
DIV, 4, clock cycles spent on each channel in scan mode (>=1)
SEL_W, 2, select/index width; must equal clog2(N); checked at elaboration

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
mode  input  1  0 = manual select, 1 = auto-scan
sel  input  SEL_W  channel select, used in manual mode only
en  input  N  per-channel enable mask, used in scan mode only
d  input  N*W  flattened channel data; channel k at d[k*W+W-1 : k*W]
q  output  W  registered selected data
ch  output  SEL_W  registered index of the channel currently on q
valid  output  1  q/ch describe a legitimate channel
tick  output  1  one-cycle pulse, high in the cycle ch has just advanced in scan mode

Behaviour:
- Reset: synchronous, active-high, dominates all other inputs. q=0, ch=0, valid=0, tick=0, prescaler pcnt=0.
- Registered core: each cycle compute ch_nxt, then q<=d[ch_nxt], ch<=ch_nxt on the same edge. Data latency is 1 cycle from d/sel to q.
- Manual mode (mode=0):
  - ch_nxt = sel; if sel>=N (non-power-of-2 N), ch_nxt=0.
  - valid<=1, tick<=0, pcnt<=0. en is ignored.
- Scan mode (mode=1):
  - pcnt counts 0..DIV-1 and wraps to 0.
  - Advance event: pcnt==DIV-1 and en!=0.
  - On an advance, ch_nxt = the first index after ch, searching ch+1, ch+2, ... with wrap N-1->0, whose en bit is 1. tick<=1.
  - If only the current channel is enabled, ch_nxt=ch; tick still pulses.
  - Otherwise ch_nxt=ch and tick<=0. q keeps refreshing from d[ch] every cycle.
  - valid<=en[ch_nxt]. A channel disabled mid-dwell drops valid on the next edge, and ch leaves it at the next advance.
  - en==0: ch holds, q<=0, valid<=0, tick<=0, pcnt keeps counting.
  - DIV=1: every cycle is an advance event.
- Mode switch manual->scan: pcnt is already 0, so the first advance comes DIV cycles later, starting from the current ch. Mode switch scan->manual: takes effect on the next edge; pcnt is cleared.
- Reset mid-scan: restarts at ch=0 with a full DIV dwell.

Optional Feature:
Macro MUX_SCAN_ONEHOT_EN.
- Defined: adds output port sel_oh [N], registered, sel_oh = 1<<ch_nxt when valid_nxt=1, else 0. Reset value 0. Intended as a direct digit-anode drive.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, N=4, W=8, manual, d={8'h44,8'h33,8'h22,8'h11}, sel=2 -> 1 cycle after reset release q=8'h33, ch=2, valid=1; change sel to 0 -> next cycle q=8'h11.
2. Scan, DIV=4, en=4'b1111 -> ch sequence 0,1,2,3,0, each held 4 cycles; tick high exactly in the first cycle of each new ch.
3. Scan, en=4'b1010 from ch=0 -> ch goes 1,3,1,3; channels 0 and 2 never appear; valid=1 throughout after the first advance.
4. Scan, drop en to 4'b0000 mid-dwell -> next cycle q=0, valid=0, ch held; restore en=4'b0100 -> first advance lands ch=2, valid=1.
5. Assert rst during scan at ch=3 -> next edge q=0, ch=0, valid=0, tick=0; after release, first advance occurs exactly DIV cycles later.
6. N=3, manual, sel=3 -> ch=0, q=d[0]; with MUX_SCAN_ONEHOT_EN, sel_oh=3'b001.
